layer_serializer: RTL
=====================

Name: layer_serializer

Overview:
- Sits directly downstream of a fully parallel neuron layer (30 neurons, 16-bit outputs, per-neuron valid bits).
- Collects every neuron output of one frame into a holding register.
- Replays the frame one value per cycle as a serial input stream (value plus valid) for the next layer's neurons.
- Tracks which slots have arrived, so neurons whose valids are not simultaneous are still handled correctly.

Parameters:
- NUM_NEURONS, 30, number of parallel inputs, equal to the upstream layer width.
- DATAWIDTH, 16, width of each neuron value (fixed-point, passed through unchanged).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_NEURONS  bit k high = slot k of x_in is valid this cycle.
- x_in  in  DATAWIDTH*NUM_NEURONS  flat input vector; slot k = x_in[k*DATAWIDTH +: DATAWIDTH].
- out_val  out  DATAWIDTH  serial value for the next layer.
- out_valid  out  1  out_val is valid this cycle.
- busy  out  1  high while in SHIFT.
- frame_done  out  1  single-cycle pulse, concurrent with the final element.
- overrun  out  1  sticky error flag; set when input arrives during SHIFT.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - out_val=0, out_valid=0, busy=0, frame_done=0, overrun=0.
  - collected flags cleared, index=0, state=IDLE, holding register=0.
- Collection, in IDLE (and in the final SHIFT cycle, see back-to-back):
  - For each k with in_valid[k]=1: latch slot k into hold[k] and set collected[k].
  - A repeated valid on an already-collected slot overwrites hold[k]; no flag is raised.
- Start: at the edge where (collected | in_valid) is all-ones, move to SHIFT with index=0 and clear collected.
- SHIFT:
  - Emission starts the cycle after the completing edge.
  - out_valid=1 and out_val=hold[index] for index 0..NUM_NEURONS-1, one element per cycle (registered outputs).
- Latency: final slot arrives in cycle N → element 0 in cycle N+1 → last element in cycle N+NUM_NEURONS.
- frame_done=1 in the cycle the last element is presented. After that edge: IDLE, out_valid=0, out_val=0.
- Index counter: $clog2(NUM_NEURONS) bits; it never exceeds NUM_NEURONS-1.
- Overrun:
  - Any in_valid bit high during SHIFT, other than in the final cycle, sets overrun.
  - That data is dropped; hold[] and the current emission are unaffected.
  - overrun stays set until rst.
- Back-to-back:
  - In the final SHIFT cycle, in_valid is treated as in IDLE: the data is collected with no overrun.
  - The last element is still emitted correctly because it is read before the edge.
  - If that collection completes a frame, the block returns to SHIFT at index 0 with zero bubble cycles.
- busy=1 exactly while out_valid=1.

Optional Feature:
- Macro: LAYER_SER_READY_EN.
- Defined:
  - Adds input port out_ready (1 bit).
  - The element advances only when out_valid && out_ready. While out_ready=0, out_val, index and out_valid hold.
  - frame_done is asserted only in the cycle the last element is accepted.
  - The "final SHIFT cycle" rules apply only to that accepting cycle.
- Undefined: no out_ready port; behaviour is identical to out_ready tied to 1.

Test Plan:
- All 30 in_valid bits high in cycle 5, slot k = k+1:
  - out_valid cycles 6..35 with out_val 1,2,…,30.
  - frame_done only in cycle 35; busy cycles 6..35; overrun=0.
- Staggered arrival, bits 0-14 in cycle 2 (values 0x0100+k) and bits 15-29 in cycle 4:
  - Emission starts cycle 5 with 0x0100, ends cycle 34; no overrun.
- Full frame, then in_valid[3]=1 with value 0xFFFF during element 10:
  - overrun=1 from the next cycle; all 30 emitted values unchanged.
  - overrun remains 1 after frame_done and in later frames until rst.
- rst pulsed during element 12:
  - out_valid/out_val/busy drop to 0 immediately.
  - A full frame presented 2 cycles after rst release emits all 30 values correctly.
- Second full frame presented in the frame_done cycle of the first:
  - Element 0 of frame 2 appears the very next cycle (60 consecutive out_valid cycles); overrun=0.
- LAYER_SER_READY_EN defined, out_ready=0 for 3 cycles while element 4 (value 5) is shown:
  - out_val holds 5 for 4 cycles; frame spans 33 cycles; frame_done coincides with acceptance of value 30.

Source files
------------

// File: rtl/layer_serializer_if.sv
// -----------------------------------------------------------------------------
// layer_serializer_if
// Bundle between a fully parallel neuron layer and the serializer, plus the
// serial stream the serializer produces for the next layer.
//   in_valid   : per-slot valid from the upstream layer
//   x_in       : flat slot vector, slot k = x_in[k*DATAWIDTH +: DATAWIDTH]
//   out_val    : serial value for the next layer
//   out_valid  : out_val is valid this cycle
//   busy       : serializer is replaying a frame
//   frame_done : pulse with the final element of a frame
//   overrun    : sticky, input arrived while replaying
//   out_ready  : downstream accept (only when LAYER_SER_READY_EN is defined)
// Modports: master = upstream/downstream environment, slave = serializer.
// -----------------------------------------------------------------------------
interface layer_serializer_if #(
  parameter int NUM_NEURONS = 30,
  parameter int DATAWIDTH   = 16
);
  logic [NUM_NEURONS-1:0]           in_valid;
  logic [DATAWIDTH*NUM_NEURONS-1:0] x_in;
  logic [DATAWIDTH-1:0]             out_val;
  logic                             out_valid;
  logic                             busy;
  logic                             frame_done;
  logic                             overrun;
`ifdef LAYER_SER_READY_EN
  logic                             out_ready;

  modport master (
    output in_valid, x_in, out_ready,
    input  out_val, out_valid, busy, frame_done, overrun
  );
  modport slave (
    input  in_valid, x_in, out_ready,
    output out_val, out_valid, busy, frame_done, overrun
  );
`else
  modport master (
    output in_valid, x_in,
    input  out_val, out_valid, busy, frame_done, overrun
  );
  modport slave (
    input  in_valid, x_in,
    output out_val, out_valid, busy, frame_done, overrun
  );
`endif
endinterface

// File: rtl/layer_serializer.sv
// -----------------------------------------------------------------------------
// layer_serializer
// Collects one frame of NUM_NEURONS parallel neuron outputs (valids may arrive
// at different times), then replays it one value per cycle as a serial stream.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   ser : layer_serializer_if.slave (in_valid, x_in in; out_val, out_valid,
//         busy, frame_done, overrun out; out_ready in when enabled)
// Build option: define LAYER_SER_READY_EN to add downstream backpressure via
// out_ready; undefined behaves as if out_ready were tied high.
// -----------------------------------------------------------------------------
module layer_serializer #(
  parameter int NUM_NEURONS = 30,
  parameter int DATAWIDTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  layer_serializer_if.slave ser
);

  localparam int              IDXW     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NEURONS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [NUM_NEURONS-1:0] collected_q, collected_d;
  logic [DATAWIDTH-1:0]   hold_q [NUM_NEURONS];
  logic [DATAWIDTH-1:0]   hold_d [NUM_NEURONS];
  logic [DATAWIDTH-1:0]   out_val_q, out_val_d;
  logic                   out_valid_q, out_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;

  logic                   advance;
  logic                   final_cyc;
  logic                   collect_en;
  logic                   frame_complete;
  logic [IDXW-1:0]        idx_inc;

`ifdef LAYER_SER_READY_EN
  assign advance = out_valid_q & ser.out_ready;
`else
  assign advance = out_valid_q;
`endif

  // The accepting cycle of the last element behaves like IDLE for collection,
  // which is what allows a following frame to start with no bubble.
  assign final_cyc      = (state_q == ST_SHIFT) && (idx_q == LAST_IDX) && advance;
  assign collect_en     = (state_q == ST_IDLE) || final_cyc;
  assign frame_complete = collect_en && (&(collected_q | ser.in_valid));
  assign idx_inc        = idx_q + 1'b1;

  // Holding register: each slot captures independently whenever collecting.
  // hold_d is also used to load element 0 in the same edge the frame completes.
  generate
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_hold
      assign hold_d[gi] = (collect_en && ser.in_valid[gi])
                          ? ser.x_in[gi*DATAWIDTH +: DATAWIDTH]
                          : hold_q[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_q[gi] <= '0;
        end else begin
          hold_q[gi] <= hold_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    collected_d  = collected_q;
    out_val_d    = out_val_q;
    out_valid_d  = out_valid_q;
    frame_done_d = frame_done_q;

    if (frame_complete) begin
      state_d      = ST_SHIFT;
      idx_d        = '0;
      collected_d  = '0;
      out_valid_d  = 1'b1;
      out_val_d    = hold_d[0];
      frame_done_d = (NUM_NEURONS == 1);
    end else if (final_cyc) begin
      state_d      = ST_IDLE;
      idx_d        = '0;
      collected_d  = collected_q | ser.in_valid;
      out_valid_d  = 1'b0;
      out_val_d    = '0;
      frame_done_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      collected_d  = collected_q | ser.in_valid;
    end else if (advance) begin
      // hold_q is stable during SHIFT, so the next element can be read directly.
      idx_d        = idx_inc;
      out_val_d    = hold_q[idx_inc];
      frame_done_d = (idx_inc == LAST_IDX);
    end

    // Input during SHIFT (outside the accepting final cycle) is dropped and flagged.
    overrun_d = overrun_q | ((state_q == ST_SHIFT) && !final_cyc && (|ser.in_valid));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      collected_q  <= '0;
      out_val_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      collected_q  <= collected_d;
      out_val_q    <= out_val_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ser.out_val   = out_val_q;
  assign ser.out_valid = out_valid_q;
  assign ser.busy      = (state_q == ST_SHIFT);
  assign ser.overrun   = overrun_q;
`ifdef LAYER_SER_READY_EN
  // While stalled on the last element, only the accepting cycle reports done.
  assign ser.frame_done = frame_done_q & ser.out_ready;
`else
  assign ser.frame_done = frame_done_q;
`endif

endmodule
